// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, types and helpers for the register-file scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

  // Default register address width and the register count derived from it.
  localparam int REG_ADDR_W = 5;
  localparam int REG_NREG   = 2 ** REG_ADDR_W;

  // Index of the hardwired-zero register (used only when REGFILE_XZR_EN is defined).
  localparam int XZR_IDX = REG_NREG - 1;

  // Widest register file the popcount helper handles. ADDR_W must stay below this.
  localparam int MAX_ADDR_W = 8;
  localparam int MAX_NREG   = 2 ** MAX_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_NREG-1:0]   reg_mask_t;

  // Population count over a mask zero-extended to MAX_NREG bits.
  function automatic logic [MAX_ADDR_W:0] popcount(input logic [MAX_NREG-1:0] v);
    logic [MAX_ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < MAX_NREG; i++) begin
      c = c + {{MAX_ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_decode_onehot.sv
// decode_onehot: binary address to one-hot vector, all zero when not enabled.
// Latency: combinational, zero cycles.
// Backpressure: none.
module decode_onehot #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]      in,
  input  logic                   en,
  output logic [2**ADDR_W-1:0]   out
);

  // Drive exactly one bit high when enabled, nothing otherwise.
  always_comb begin
    out = '0;
    if (en) begin
      out[in] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: writeback one-hot decoder plus pending-write scoreboard with RAW/WAW stall.
// Latency: wr_en/issue_ready combinational; busy/busy_count update one cycle after the edge.
// Backpressure: issue_ready drops on a hazard or flush. Optional macro REGFILE_XZR_EN makes reg NREG-1 hardwired zero.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  localparam int NREG  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              src_a_used,
  input  logic [ADDR_W-1:0] src_a_addr,
  input  logic              src_b_used,
  input  logic [ADDR_W-1:0] src_b_addr,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              flush,
  output logic [NREG-1:0]   wr_en,
  output logic [NREG-1:0]   busy,
  output logic [ADDR_W:0]   busy_count
);

  logic [NREG-1:0]     busy_q, busy_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [NREG-1:0]     wr_raw, set_raw, set_mask, busy_eff;
  logic                hazard, accept;
  logic [MAX_NREG-1:0] busy_wide;
  logic [MAX_ADDR_W:0] pop_all;
  logic                unused_pop_hi;

  decode_onehot #(.ADDR_W(ADDR_W)) u_wb_dec (
    .in  (wb_addr),
    .en  (wb_valid),
    .out (wr_raw)
  );

  decode_onehot #(.ADDR_W(ADDR_W)) u_set_dec (
    .in  (issue_addr),
    .en  (accept),
    .out (set_raw)
  );

`ifdef REGFILE_XZR_EN
  // Top register reads as zero: never written, never marked pending.
  localparam logic [NREG-1:0] XZR_MASK = {1'b1, {(NREG-1){1'b0}}};
  assign wr_en    = wr_raw  & ~XZR_MASK;
  assign set_mask = set_raw & ~XZR_MASK;
`else
  assign wr_en    = wr_raw;
  assign set_mask = set_raw;
`endif

  // A same-cycle writeback clears the hazard since the file writes before it reads.
  assign busy_eff = busy_q & ~wr_en;

  // RAW on either used source, or WAW on the destination; evaluated even without issue_valid.
  always_comb begin
    hazard = 1'b0;
    if (src_a_used && busy_eff[src_a_addr]) hazard = 1'b1;
    if (src_b_used && busy_eff[src_b_addr]) hazard = 1'b1;
    if (busy_eff[issue_addr])               hazard = 1'b1;
  end

  assign issue_ready = !hazard && !flush;
  assign accept      = issue_valid && issue_ready;

  // Next pending vector: flush wipes everything, otherwise clear on writeback then set on accept.
  always_comb begin
    busy_d = '0;
    if (!flush) begin
      busy_d = busy_eff | set_mask;
    end
`ifdef REGFILE_XZR_EN
    busy_d[NREG-1] = 1'b0;
`endif
  end

  // Zero-extend to the helper width so one popcount serves any ADDR_W.
  always_comb begin
    busy_wide            = '0;
    busy_wide[NREG-1:0]  = busy_d;
  end

  assign pop_all       = popcount(busy_wide);
  assign count_d       = pop_all[ADDR_W:0];
  assign unused_pop_hi = |pop_all[MAX_ADDR_W:ADDR_W+1];

  // Pending-write state and its population count, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy       = busy_q;
  assign busy_count = count_q;

endmodule
